// File: rtl/rca_pkg.sv
// Width helpers shared by the pipelined adders.
// Defines how an n-bit add is cut into k carry-linked chunks.
package rca_pkg;

    // Chunk width for the first k-1 chunks: ceil(n/k).
    function automatic int chunk_w(input int n, input int k);
        if (k < 1) return 0;
        return (n + k - 1) / k;
    endfunction

    // Whatever is left over for the final chunk; must come out >= 1.
    function automatic int last_w(input int n, input int k);
        return n - (k - 1) * chunk_w(n, k);
    endfunction

endpackage

// File: rtl/rca_nbits.sv
// Flat n-bit ripple-carry adder, purely combinational.
// Zero latency, no flow control.
module rca_nbits #(
    parameter int n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);

    logic [n:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cin;
        for (int i = 0; i < n; i++) begin
            s[i]         = x[i] ^ y[i] ^ carry[i];
            carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
    end

    assign cout = carry[n];

endmodule

// File: rtl/pipe_rca_nbits.sv
// Pipelined n-bit adder: one ripple chunk per stage, k-cycle latency, 1 result/clock.
// Valid/ready throughout; a stage loads when empty or when the stage ahead moves, so bubbles collapse.
module pipe_rca_nbits
    import rca_pkg::*;
#(
    parameter int n = 34,
    parameter int k = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         cin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] s,
    output logic         cout,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int W  = chunk_w(n, k);
    localparam int LW = last_w(n, k);

    if (k < 1 || k > n || LW < 1) begin : g_bad_cfg
        $error("pipe_rca_nbits: illegal n/k combination");
    end

    // Stage registers, indexed 1..k; stage k drives the outputs.
    logic         v_q   [1:k];
    logic         c_q   [1:k];
    logic [n-1:0] x_q   [1:k];
    logic [n-1:0] y_q   [1:k];
    logic [n-1:0] sum_q [1:k];

    logic         ld    [1:k];
    logic [n-1:0] sum_d [1:k];
    logic         c_d   [1:k];

    // Chunk j reads from source j: the input ports for j = 0, stage j otherwise.
    logic         v_src   [0:k-1];
    logic         c_src   [0:k-1];
    logic [n-1:0] x_src   [0:k-1];
    logic [n-1:0] y_src   [0:k-1];
    logic [n-1:0] sum_src [0:k-1];

    always_comb begin
        v_src[0]   = in_valid;
        c_src[0]   = cin;
        x_src[0]   = x;
        y_src[0]   = y;
        sum_src[0] = '0;
        for (int j = 1; j < k; j++) begin
            v_src[j]   = v_q[j];
            c_src[j]   = c_q[j];
            x_src[j]   = x_q[j];
            y_src[j]   = y_q[j];
            sum_src[j] = sum_q[j];
        end
    end

    // Ready chain runs back from the output; in_ready never looks at in_valid.
    always_comb begin
        ld[k] = !v_q[k] || out_ready;
        for (int j = k - 1; j >= 1; j--) begin
            ld[j] = !v_q[j] || ld[j + 1];
        end
    end

    assign in_ready = ld[1];

    for (genvar j = 0; j < k; j++) begin : g_chunk
        localparam int CW = (j == k - 1) ? LW : W;
        localparam int LO = j * W;

        logic [CW-1:0] add_s;
        logic          add_co;
        logic [n-1:0]  merged;

        rca_nbits #(.n(CW)) u_rca (
            .x    (x_src[j][LO +: CW]),
            .y    (y_src[j][LO +: CW]),
            .cin  (c_src[j]),
            .s    (add_s),
            .cout (add_co)
        );

        always_comb begin
            merged           = sum_src[j];
            merged[LO +: CW] = add_s;
        end

        assign sum_d[j + 1] = merged;
        assign c_d[j + 1]   = add_co;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 1; j <= k; j++) begin
                v_q[j]   <= 1'b0;
                c_q[j]   <= 1'b0;
                x_q[j]   <= '0;
                y_q[j]   <= '0;
                sum_q[j] <= '0;
            end
        end else begin
            for (int j = 1; j <= k; j++) begin
                if (ld[j]) begin
                    v_q[j]   <= v_src[j - 1];
                    c_q[j]   <= c_d[j];
                    x_q[j]   <= x_src[j - 1];
                    y_q[j]   <= y_src[j - 1];
                    sum_q[j] <= sum_d[j];
                end
            end
        end
    end

    assign s         = sum_q[k];
    assign cout      = c_q[k];
    assign out_valid = v_q[k];

endmodule

// File: tb/tb_pipe_rca_nbits.sv
// Bench for pipe_rca_nbits: lane 0 is n=34/k=4, lane 1 is n=34/k=34, plus an n=16/k=1 instance.
module tb_pipe_rca_nbits;

    localparam int NRAND = 10000;

    logic clk;
    logic rst_n;

    // Two 34-bit lanes: [0] k=4, [1] k=34
    logic [33:0] lx  [2];
    logic [33:0] ly  [2];
    logic        lc  [2];
    logic        lv  [2];
    logic        lr  [2];
    logic [33:0] ls  [2];
    logic        lco [2];
    logic        lov [2];
    logic        lor [2];

    logic [15:0] x1, y1, s1;
    logic        c1, v1, r1, co1, ov1, or1;

    pipe_rca_nbits #(.n(34), .k(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .x(lx[0]), .y(ly[0]), .cin(lc[0]),
        .in_valid(lv[0]), .in_ready(lr[0]), .s(ls[0]), .cout(lco[0]),
        .out_valid(lov[0]), .out_ready(lor[0])
    );

    pipe_rca_nbits #(.n(34), .k(34)) dut34 (
        .clk(clk), .rst_n(rst_n), .x(lx[1]), .y(ly[1]), .cin(lc[1]),
        .in_valid(lv[1]), .in_ready(lr[1]), .s(ls[1]), .cout(lco[1]),
        .out_valid(lov[1]), .out_ready(lor[1])
    );

    pipe_rca_nbits #(.n(16), .k(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .cin(c1),
        .in_valid(v1), .in_ready(r1), .s(s1), .cout(co1),
        .out_valid(ov1), .out_ready(or1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_chk;
    int          n_fail;
    int          cyc;
    int          n_del   [2];
    int          n_acc   [2];
    bit          acc     [2];
    bit          del     [2];
    logic [34:0] exp_nxt [2];
    logic [34:0] q0 [$];
    logic [34:0] q1 [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic score(input int l);
        logic [34:0] want;
        int          have;
        have = (l == 0) ? q0.size() : q1.size();
        check_eq($sformatf("pending%0d", l), 64'(have != 0), 64'd1);
        if (have != 0) begin
            want = (l == 0) ? q0.pop_front() : q1.pop_front();
            check_eq($sformatf("result%0d", l), 64'({lco[l], ls[l]}), 64'(want));
            n_del[l]++;
        end
    endtask

    // Settle, note transfers, score deliveries, queue acceptances, advance one clock.
    task automatic step();
        #1;
        for (int l = 0; l < 2; l++) begin
            acc[l] = lv[l] && lr[l];
            del[l] = lov[l] && lor[l];
        end
        for (int l = 0; l < 2; l++) begin
            if (del[l]) score(l);
        end
        if (acc[0]) q0.push_back(exp_nxt[0]);
        if (acc[1]) q1.push_back(exp_nxt[1]);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int j;
        int base;
        int first_c;
        int last_c;
        int base1;

        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        for (int l = 0; l < 2; l++) begin
            lx[l] = '0; ly[l] = '0; lc[l] = 1'b0; lv[l] = 1'b0; lor[l] = 1'b0;
            n_del[l] = 0; n_acc[l] = 0; exp_nxt[l] = '0;
        end
        x1 = '0; y1 = '0; c1 = 1'b0; v1 = 1'b0; or1 = 1'b0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", lov[0], 1'b0);
        check_eq("rst_in_ready", lr[0], 1'b1);
        check_eq("rst_s", ls[0], 34'd0);
        check_eq("rst_cout", lco[0], 1'b0);
        check_eq("rst_out_valid_k34", lov[1], 1'b0);
        check_eq("rst_out_valid_k1", ov1, 1'b0);
        rst_n = 1'b1;
        lor[1] = 1'b1;

        // Full carry ripple on k=4; all-ones plus carry on k=1
        lv[0] = 1'b1; lx[0] = 34'h3_FFFF_FFFF; ly[0] = 34'h1; lc[0] = 1'b0; lor[0] = 1'b1;
        v1 = 1'b1; x1 = 16'hFFFF; y1 = 16'hFFFF; c1 = 1'b1; or1 = 1'b0;
        #1;
        check_eq("ripple_accept", lr[0], 1'b1);
        check_eq("k1_accept", r1, 1'b1);
        @(posedge clk);
        #1;
        lv[0] = 1'b0;
        v1 = 1'b0;
        check_eq("ripple_lat_e0", lov[0], 1'b0);
        check_eq("k1_out_valid", ov1, 1'b1);
        check_eq("k1_sum", {co1, s1}, 17'h1_FFFF);
        check_eq("k1_full_in_ready", r1, 1'b0);
        or1 = 1'b1;
        #1;
        check_eq("k1_ready_release", r1, 1'b1);
        @(posedge clk);
        #1;
        check_eq("ripple_lat_e1", lov[0], 1'b0);
        check_eq("k1_drained", ov1, 1'b0);
        @(posedge clk);
        #1;
        check_eq("ripple_lat_e2", lov[0], 1'b0);
        @(posedge clk);
        #1;
        check_eq("ripple_lat_e3", lov[0], 1'b1);
        check_eq("ripple_s", ls[0], 34'd0);
        check_eq("ripple_cout", lco[0], 1'b1);
        @(posedge clk);
        #1;
        check_eq("ripple_drained", lov[0], 1'b0);

        // Back-to-back streaming of (i, 2i, i[0])
        base = n_del[0];
        first_c = -1;
        last_c = -1;
        for (int i = 0; i < 8; i++) begin
            lv[0] = 1'b1; lx[0] = 34'(i); ly[0] = 34'(2 * i); lc[0] = (i % 2) == 1;
            exp_nxt[0] = 35'(3 * i + (i % 2));
            step();
            check_eq("stream_in_ready", acc[0], 1'b1);
            if (del[0]) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
        end
        lv[0] = 1'b0;
        for (int c = 0; c < 12 && n_del[0] - base < 8; c++) begin
            step();
            if (del[0]) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
        end
        check_eq("stream_count", n_del[0] - base, 8);
        check_eq("stream_consecutive", last_c - first_c, 7);

        // Backpressure: 6 offered with out_ready low, only 4 fit
        base = n_del[0];
        lor[0] = 1'b0;
        j = 0;
        for (int c = 0; c < 6; c++) begin
            lv[0] = 1'b1; lx[0] = 34'(100 + j); ly[0] = 34'(7 * j); lc[0] = 1'b0;
            exp_nxt[0] = 35'(100 + 8 * j);
            step();
            if (acc[0]) j++;
            if (lov[0]) check_eq("bp_hold_s", ls[0], 34'd100);
        end
        check_eq("bp_accepted", j, 4);
        check_eq("bp_in_ready_full", lr[0], 1'b0);
        check_eq("bp_out_valid", lov[0], 1'b1);
        lor[0] = 1'b1;
        #1;
        check_eq("bp_ready_release", lr[0], 1'b1);
        for (int c = 0; c < 20 && n_del[0] - base < 6; c++) begin
            lv[0] = (j < 6); lx[0] = 34'(100 + j); ly[0] = 34'(7 * j); lc[0] = 1'b0;
            exp_nxt[0] = 35'(100 + 8 * j);
            step();
            if (acc[0]) j++;
        end
        lv[0] = 1'b0;
        check_eq("bp_all_accepted", j, 6);
        check_eq("bp_all_delivered", n_del[0] - base, 6);

        // Reset with three operands in flight
        lor[0] = 1'b0;
        j = 0;
        for (int c = 0; c < 4; c++) begin
            lv[0] = (j < 3); lx[0] = 34'(5 + j); ly[0] = 34'd0; lc[0] = 1'b0;
            exp_nxt[0] = 35'(5 + j);
            step();
            if (acc[0]) j++;
        end
        lv[0] = 1'b0;
        check_eq("midrst_pre_valid", lov[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_async_valid", lov[0], 1'b0);
        check_eq("midrst_in_ready", lr[0], 1'b1);
        check_eq("midrst_s", ls[0], 34'd0);
        q0.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lor[0] = 1'b1;
        base = n_del[0];
        j = 0;
        for (int c = 0; c < 12; c++) begin
            lv[0] = (j < 2);
            lx[0] = (j == 0) ? 34'd9 : 34'd20;
            ly[0] = (j == 0) ? 34'd1 : 34'd22;
            lc[0] = (j != 0);
            exp_nxt[0] = (j == 0) ? 35'd10 : 35'd43;
            step();
            if (acc[0]) j++;
        end
        lv[0] = 1'b0;
        check_eq("midrst_new_delivered", n_del[0] - base, 2);

        // Random compare on both 34-bit lanes
        base  = n_del[0];
        base1 = n_del[1];
        for (int c = 0; c < 60000; c++) begin
            if (n_del[0] - base >= NRAND && n_del[1] - base1 >= NRAND) break;
            for (int l = 0; l < 2; l++) begin
                lv[l]  = (n_acc[l] < NRAND) && ($urandom_range(3) != 0);
                lx[l]  = 34'({$urandom, $urandom});
                ly[l]  = 34'({$urandom, $urandom});
                lc[l]  = 1'($urandom_range(1));
                lor[l] = ($urandom_range(3) != 0);
                exp_nxt[l] = {1'b0, lx[l]} + {1'b0, ly[l]} + 35'(lc[l]);
            end
            step();
            for (int l = 0; l < 2; l++) begin
                if (acc[l]) n_acc[l]++;
            end
        end
        check_eq("rand_k4_delivered", n_del[0] - base, NRAND);
        check_eq("rand_k34_delivered", n_del[1] - base1, NRAND);
        check_eq("rand_k4_queue_empty", q0.size(), 0);
        check_eq("rand_k34_queue_empty", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
